// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   DEF_WIDTH : default operand width (divisor / quotient / remainder bits)
//   state_t   : divider FSM state encoding
package seq_div_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle of the sequential signed divider.
//   en   : start request, held by the requester until done is seen
//   N    : signed dividend, 2*width bits
//   D    : signed divisor, width bits
//   done : result valid, held until en drops
//   Q, R : signed quotient / remainder, width bits
//   ovf  : divide-by-zero or quotient out of range
// master = requester side, slave = divider side.
interface seq_div_if
  import seq_div_pkg::*;
#(
  parameter int width = DEF_WIDTH
) ();

  logic                      en;
  logic signed [2*width-1:0] N;
  logic signed [width-1:0]   D;
  logic                      done;
  logic signed [width-1:0]   Q;
  logic signed [width-1:0]   R;
  logic                      ovf;

  modport master (output en, N, D, input done, Q, R, ovf);
  modport slave  (input en, N, D, output done, Q, R, ovf);

endinterface

// File: rtl/div_abs.sv
// Two's-complement magnitude.
//   a   : signed input, width bits
//   mag : unsigned magnitude, width bits
// The most negative input maps to 2^(width-1), which still fits as an
// unsigned width-bit value, so no widening is needed.
module div_abs
  import seq_div_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic signed [width-1:0] a,
  output logic        [width-1:0] mag
);

  assign mag = a[width-1] ? $unsigned(-a) : $unsigned(a);

endmodule

// File: rtl/seq_div.sv
// Sequential signed divider: 2*width-bit dividend by width-bit divisor,
// restoring shift-subtract on magnitudes, one quotient bit per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_div_if slave (en, N, D in; done, Q, R, ovf out)
// Sequence: IDLE latches operands, CALC runs width steps, FIX applies
// signs and range checks, DONE holds the result until en drops.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int width = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);

  localparam int                CW       = $clog2(width + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(width - 1);
  localparam logic [width-1:0]  MAX_POS  = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0]  MAX_NEG  = {1'b1, {(width-1){1'b0}}};

  logic [2*width-1:0] n_mag;
  logic [width-1:0]   d_mag;

  div_abs #(.width(2*width)) u_abs_n (.a(bus.N), .mag(n_mag));
  div_abs #(.width(width))   u_abs_d (.a(bus.D), .mag(d_mag));

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [width-1:0]        rem_q, rem_d;
  logic [width-1:0]        quo_q, quo_d;
  logic [width-1:0]        dmag_q, dmag_d;
  logic                    q_neg_q, q_neg_d;
  logic                    r_neg_q, r_neg_d;
  logic                    ovf_u_q, ovf_u_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;
  logic signed [width-1:0] qout_q, qout_d;
  logic signed [width-1:0] rout_q, rout_d;

  logic [width:0]          rem_sh;
  logic                    sub_ok;
  logic [2*width:0]        fix_res;

  // Sign correction and range check; returns {ovf, Q, R}, with Q/R zeroed
  // on overflow. A negative quotient may reach magnitude 2^(width-1).
  function automatic logic [2*width:0] fix_result(
    input logic [width-1:0] qm,
    input logic [width-1:0] rm,
    input logic             qn,
    input logic             rn,
    input logic             ovf_u
  );
    logic             o;
    logic [width-1:0] qv;
    logic [width-1:0] rv;
    o  = ovf_u | (!qn && (qm > MAX_POS)) | (qn && (qm > MAX_NEG));
    qv = qn ? (-qm) : qm;
    rv = rn ? (-rm) : rm;
    if (o) begin
      qv = '0;
      rv = '0;
    end
    return {o, qv, rv};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.en) state_d = ST_CALC;
      ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: if (!bus.en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    ovf_u_d = ovf_u_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    qout_d  = qout_q;
    rout_d  = rout_q;

    // Partial remainder shifted left, pulling in the next dividend bit.
    rem_sh  = {rem_q, quo_q[width-1]};
    sub_ok  = (rem_sh >= {1'b0, dmag_q});
    fix_res = fix_result(quo_q, rem_q, q_neg_q, r_neg_q, ovf_u_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          rem_d   = n_mag[2*width-1:width];
          quo_d   = n_mag[width-1:0];
          dmag_d  = d_mag;
          q_neg_d = bus.N[2*width-1] ^ bus.D[width-1];
          r_neg_d = bus.N[2*width-1];
          // Upper half >= divisor means the quotient needs more than width
          // bits; this also covers D = 0.
          ovf_u_d = (n_mag[2*width-1:width] >= d_mag);
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        // Low width bits of the difference are exact: when sub_ok holds the
        // result is below the divisor.
        rem_d = sub_ok ? (rem_sh[width-1:0] - dmag_q) : rem_sh[width-1:0];
        quo_d = {quo_q[width-2:0], sub_ok};
        cnt_d = cnt_q + CW'(1);
      end
      ST_FIX: begin
        {ovf_d, qout_d, rout_d} = fix_res;
        done_d = 1'b1;
      end
      ST_DONE: begin
        if (!bus.en) done_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      ovf_u_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      ovf_u_q <= ovf_u_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
    end
  end

  assign bus.done = done_q;
  assign bus.Q    = qout_q;
  assign bus.R    = rout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (width = 8): directed vectors with
// hand-computed results, then randomized operands against a plain-arithmetic
// reference model. A monitor compares outputs on every cycle done is high.
module tb_seq_div;

  localparam int W   = 8;
  localparam int LAT = W + 2;  // edges from the en-sampling edge (inclusive) to done

  logic clk;
  logic rst_n;

  seq_div_if #(.width(W)) bus ();

  seq_div #(.width(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint exp_q;
  longint exp_r;
  bit     exp_o;
  bit     mon_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: signed division truncating toward zero, remainder takes the
  // dividend's sign; anything outside the width-bit signed range overflows.
  function automatic void model(input longint n, input longint d,
                                output longint q, output longint r, output bit o);
    longint qmax;
    longint qmin;
    qmax = (longint'(1) << (W - 1)) - 1;
    qmin = -(longint'(1) << (W - 1));
    if (d == 0) begin
      o = 1'b1; q = 0; r = 0;
    end else begin
      q = n / d;
      r = n % d;
      if (q > qmax || q < qmin) begin
        o = 1'b1; q = 0; r = 0;
      end else begin
        o = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (mon_en && bus.done) begin
      chk("mon_Q",   longint'(bus.Q), exp_q);
      chk("mon_R",   longint'(bus.R), exp_r);
      chk("mon_ovf", longint'(bus.ovf), longint'(exp_o));
    end
  end

  task automatic run_op(input longint n, input longint d, input int hold);
    int lat;
    model(n, d, exp_q, exp_r, exp_o);
    mon_en = 1'b1;
    @(negedge clk);
    bus.N  = (2*W)'(n);
    bus.D  = W'(d);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    chk("busy_at_start", longint'(bus.done), 0);
    // Operand changes while busy must not affect the result.
    bus.N = (2*W)'($urandom);
    bus.D = W'($urandom);
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, LAT);
    chk("op_Q",   longint'(bus.Q), exp_q);
    chk("op_R",   longint'(bus.R), exp_r);
    chk("op_ovf", longint'(bus.ovf), longint'(exp_o));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.N = (2*W)'($urandom);
      bus.D = W'($urandom);
    end
    if (hold > 0) begin
      @(posedge clk);
      #1;
      chk("held_done", longint'(bus.done), 1);
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clear", longint'(bus.done), 0);
    chk("keep_Q",     longint'(bus.Q), exp_q);
    chk("keep_R",     longint'(bus.R), exp_r);
    chk("keep_ovf",   longint'(bus.ovf), longint'(exp_o));
  endtask

  longint dn [12] = '{56, -100, 100, -100, 123, 16384, -8192, 8192, -32768, -32768, 127, -1};
  longint dd [12] = '{ 7,    7,  -7,   -7,   0,    64,    64,   64,      1,   -128,  -1,  5};
  longint eq [12] = '{ 8,  -14, -14,   14,   0,     0,  -128,    0,      0,      0, -127,  0};
  longint er [12] = '{ 0,   -2,   2,   -2,   0,     0,     0,    0,      0,      0,    0, -1};
  bit     eo [12] = '{ 0,    0,   0,    0,   1,     1,     0,    1,      1,      1,    0,  0};

  initial begin
    longint mq, mr;
    bit     mo;
    bit     saw;
    longint qv, dv, prod, rmag, r, n;

    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.N  = '0;
    bus.D  = '0;
    #12;
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_Q",    longint'(bus.Q), 0);
    chk("rst_R",    longint'(bus.R), 0);
    chk("rst_ovf",  longint'(bus.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: pin the model to hand-computed values, then run DUT.
    for (int i = 0; i < 12; i++) begin
      model(dn[i], dd[i], mq, mr, mo);
      chk("model_Q",   mq, eq[i]);
      chk("model_R",   mr, er[i]);
      chk("model_ovf", longint'(mo), longint'(eo[i]));
      run_op(dn[i], dd[i], (i == 6) ? 20 : 0);
    end

    // Reset in the middle of CALC aborts without a done pulse.
    run_op(-100, -7, 0);
    mon_en = 1'b0;
    @(negedge clk);
    bus.N  = 16'(56);
    bus.D  = 8'(7);
    bus.en = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_done", longint'(bus.done), 0);
    chk("abort_Q",    longint'(bus.Q), 0);
    chk("abort_R",    longint'(bus.R), 0);
    chk("abort_ovf",  longint'(bus.ovf), 0);
    bus.en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      saw = saw | bus.done;
    end
    chk("no_done_after_abort", longint'(saw), 0);
    run_op(56, 7, 0);

    // Randomized operands: mostly constructed to land near the valid range,
    // some raw draws (mostly overflow) and some divide-by-zero.
    for (int k = 0; k < 200; k++) begin
      if (k % 25 == 0) begin
        n  = longint'($signed(16'($urandom)));
        dv = 0;
      end else if (k % 7 == 0) begin
        n  = longint'($signed(16'($urandom)));
        dv = longint'($signed(8'($urandom)));
      end else begin
        qv = longint'($urandom_range(0, 280)) - 140;
        dv = longint'($urandom_range(0, 255)) - 128;
        if (dv == 0) dv = 1;
        prod = qv * dv;
        rmag = longint'($urandom) % ((dv < 0) ? -dv : dv);
        if (prod < 0)      r = -rmag;
        else if (prod > 0) r = rmag;
        else               r = ($urandom_range(0, 1) == 1) ? -rmag : rmag;
        n = prod + r;
      end
      run_op(n, dv, int'($urandom_range(0, 3)));
    end

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter: width, default 8, operand width (divisor, quotient, remainder) in bits.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  start request, level-held by requester until done observed.
REQ-005 N  input  2*width  signed dividend (two's complement).
REQ-006 D  input  width  signed divisor (two's complement).
REQ-007 done  output  1  result valid, held until en deasserted.
REQ-008 Q  output  width  signed quotient.
REQ-009 R  output  width  signed remainder.
REQ-010 ovf  output  1  divide-by-zero or quotient not representable in width bits.

Function
REQ-011 Division SHALL be signed, quotient truncated toward zero, remainder sign equal to dividend sign, N = Q*D + R with |R| < |D|.
REQ-012 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-013 IDLE: on an edge with en=1, SHALL latch N and D, compute magnitudes and result signs, clear the iteration counter, and go to CALC.
REQ-014 CALC: SHALL perform one restoring shift-subtract step on unsigned magnitudes per cycle, for exactly width cycles, then go to FIX.
REQ-015 FIX: SHALL apply sign correction to quotient and remainder, evaluate ovf, load Q/R/ovf, set done, and go to DONE.
REQ-016 Latency: en sampled at edge k -> done=1 and Q/R/ovf valid after edge k+width+1 (10 cycles for width=8).
REQ-017 DONE: done, Q, R, ovf SHALL hold while en=1; on the first edge with en=0, done SHALL clear and FSM SHALL return to IDLE; Q/R/ovf SHALL retain their values.
REQ-018 N, D and en changes during CALC/FIX SHALL be ignored.
REQ-019 D=0: SHALL take the same latency, with ovf=1, Q=0, R=0.
REQ-020 Unsigned overflow (|N| upper width bits >= |D|) SHALL give ovf=1, Q=0, R=0.
REQ-021 Signed range: positive quotient >2^(width-1)-1 or negative quotient magnitude >2^(width-1) SHALL give ovf=1, Q=0, R=0; quotient -2^(width-1) SHALL be valid.
REQ-022 N=-2^(2*width-1) SHALL be handled via 2*width-bit unsigned magnitude, without internal wrap.
REQ-023 en held high continuously SHALL NOT restart until en has been seen low in DONE.

Reset
REQ-024 rst_n low SHALL immediately force FSM to IDLE, done=0, Q=0, R=0, ovf=0, counter=0, internal registers cleared.
REQ-025 Reset mid-CALC/FIX SHALL abort the operation with no done pulse; after release, the next en=1 SHALL start a fresh operation.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef/encoding and the default width constant.
REQ-027 One sub-module, div_abs (two's-complement magnitude, parameterised width), SHALL be instantiated for N and D; all else in seq_div.

Verification (width=8)
REQ-028 N=56, D=7, en=1 -> Q=8, R=0, ovf=0, done exactly 10 cycles after en sample.
REQ-029 N=-100, D=7 -> Q=-14, R=-2; N=100, D=-7 -> Q=-14, R=2; N=-100, D=-7 -> Q=14, R=-2.
REQ-030 N=123, D=0 -> ovf=1, Q=0, R=0, same 10-cycle latency.
REQ-031 N=16384, D=64 -> ovf=1 (quotient 256); N=-8192, D=64 -> Q=-128, R=0, ovf=0; N=8192, D=64 -> ovf=1 (128).
REQ-032 rst_n low at cycle 4 of CALC -> done=0, Q=R=0 immediately; rerun N=56, D=7 -> Q=8 after 10 cycles.
REQ-033 en held high for 20 cycles after done -> outputs stable, no second operation; en low then high -> new result.
